// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier: operand register, unpack/classify,
// significand product, then normalise/round/pack into the output register.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] num1,
    input  logic [EXP_W+MAN_W:0] num2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Round-to-nearest-even increment decision.
    function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

    // Range saturation of the normal path, returns {flags, word}.
    function automatic logic [W+3:0] pack_normal(
        input logic                  s,
        input logic signed [EW-1:0]  e_norm,
        input logic signed [EW-1:0]  e_rnd,
        input logic [MAN_W-1:0]      frac,
        input logic                  inexact
    );
        if (e_norm <= EZERO)
            return {4'b0011, s, {(W-1){1'b0}}};
        else if (e_rnd >= EMAX)
            return {4'b0101, s, EXP_ONES, {MAN_W{1'b0}}};
        else
            return {3'b000, inexact, s, e_rnd[EXP_W-1:0], frac};
    endfunction

    logic en;
    assign in_ready = !out_valid || out_ready;
    assign en       = in_ready;

    logic                 vld_p0, vld_p1, vld_p2;
    logic [W-1:0]         num1_p0, num2_p0;
    logic                 sign_p1, sign_p2;
    logic signed [EW-1:0] exp_p1, exp_p2;
    logic [SW-1:0]        siga_p1, sigb_p1;
    logic [PW-1:0]        prod_p2;
    logic                 spec_p1, spec_p2;
    logic [W-1:0]         spec_res_p1, spec_res_p2;
    logic [3:0]           spec_flg_p1, spec_flg_p2;

    // ---- stage 1: unpack and classify (from _p0) ----
    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b, inv_mul;
    logic                 s1_spec;
    logic [W-1:0]         s1_res;
    logic [3:0]           s1_flg;
    logic signed [EW-1:0] s1_exp;

    assign sa = num1_p0[W-1];
    assign sb = num2_p0[W-1];
    assign ea = num1_p0[W-2 -: EXP_W];
    assign eb = num2_p0[W-2 -: EXP_W];
    assign fa = num1_p0[MAN_W-1:0];
    assign fb = num2_p0[MAN_W-1:0];

    assign zero_a  = (ea == '0);
    assign zero_b  = (eb == '0);
    assign inf_a   = (ea == EXP_ONES) && (fa == '0);
    assign inf_b   = (eb == EXP_ONES) && (fb == '0);
    assign nan_a   = (ea == EXP_ONES) && (fa != '0);
    assign nan_b   = (eb == EXP_ONES) && (fb != '0);
    assign snan_a  = nan_a && !fa[MAN_W-1];
    assign snan_b  = nan_b && !fb[MAN_W-1];
    assign inv_mul = (inf_a && zero_b) || (zero_a && inf_b);
    assign s1_exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    always_comb begin
        s1_spec = 1'b1;
        s1_res  = '0;
        s1_flg  = '0;
        if (nan_a || nan_b || inv_mul) begin
            s1_res = QNAN;
            s1_flg = {inv_mul || snan_a || snan_b, 3'b000};
        end else if (inf_a || inf_b) begin
            s1_res = {sa ^ sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (zero_a || zero_b) begin
            s1_res = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
            s1_spec = 1'b0;
        end
    end

    // ---- stage 3: normalise, round, pack (from _p2) ----
    logic                 top, guard, sticky;
    logic [MAN_W-1:0]     frac_n;
    logic [MAN_W:0]       rnd;
    logic signed [EW-1:0] e_norm, e_rnd;
    logic [W+3:0]         norm_out;
    logic [W-1:0]         s3_res;
    logic [3:0]           s3_flg;

    assign top    = prod_p2[PW-1];
    assign frac_n = top ? prod_p2[PW-2 -: MAN_W] : prod_p2[PW-3 -: MAN_W];
    assign guard  = top ? prod_p2[MAN_W] : prod_p2[MAN_W-1];
    assign sticky = top ? |prod_p2[MAN_W-1:0] : |prod_p2[MAN_W-2:0];
    assign e_norm = exp_p2 + $signed({{(EW-1){1'b0}}, top});
    assign rnd    = {1'b0, frac_n} + {{MAN_W{1'b0}}, rne_up(frac_n[0], guard, sticky)};
    assign e_rnd  = e_norm + $signed({{(EW-1){1'b0}}, rnd[MAN_W]});
    assign norm_out = pack_normal(sign_p2, e_norm, e_rnd, rnd[MAN_W-1:0], guard | sticky);
    assign {s3_flg, s3_res} = spec_p2 ? {spec_flg_p2, spec_res_p2} : norm_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (en) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            result    <= s3_res;
            flags     <= s3_flg;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // ---- stage 0 -> 1 boundary ----
            num1_p0     <= num1;
            num2_p0     <= num2;
            // ---- stage 1 -> 2 boundary ----
            sign_p1     <= sa ^ sb;
            exp_p1      <= s1_exp;
            siga_p1     <= {1'b1, fa};
            sigb_p1     <= {1'b1, fb};
            spec_p1     <= s1_spec;
            spec_res_p1 <= s1_res;
            spec_flg_p1 <= s1_flg;
            // ---- stage 2 -> 3 boundary ----
            sign_p2     <= sign_p1;
            exp_p2      <= exp_p1;
            prod_p2     <= PW'(siga_p1) * PW'(sigb_p1);
            spec_p2     <= spec_p1;
            spec_res_p2 <= spec_res_p1;
            spec_flg_p2 <= spec_flg_p1;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vectors, flow control, reset flush, half
// precision instance and randomized traffic against an arithmetic model.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] num1, num2, result;
    logic [3:0]  flags;
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_num1, h_num2, h_result;
    logic [3:0]  h_flags;

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .num1(h_num1), .num2(h_num2), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    int total = 0;
    int bad = 0;
    int stall_cycles = 0;
    logic [35:0] expq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Exact significand product, then quotient/remainder rounding.
    function automatic void ref_mul(input longint unsigned a, input longint unsigned b,
                                    input int ew, input int mw,
                                    output longint unsigned res, output logic [3:0] flg);
        longint unsigned mmask, fa, fb, p, q, r, half, sgn, qnan, infv;
        int emaxf, bias, ea, eb, e, sh;
        bit za, zb, ia, ib, na, nb, sna, snb, inv0;
        mmask = (64'd1 << mw) - 1;
        emaxf = (1 << ew) - 1;
        bias  = (1 << (ew - 1)) - 1;
        fa = a & mmask;
        fb = b & mmask;
        ea = int'((a >> mw) & longint'(emaxf));
        eb = int'((b >> mw) & longint'(emaxf));
        sgn  = (((a ^ b) >> (ew + mw)) & 64'd1) << (ew + mw);
        qnan = (longint'(emaxf) << mw) | (64'd1 << (mw - 1));
        infv = sgn | (longint'(emaxf) << mw);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == emaxf) && (fa == 0); ib = (eb == emaxf) && (fb == 0);
        na = (ea == emaxf) && (fa != 0); nb = (eb == emaxf) && (fb != 0);
        sna = na && (((fa >> (mw - 1)) & 64'd1) == 0);
        snb = nb && (((fb >> (mw - 1)) & 64'd1) == 0);
        inv0 = (ia && zb) || (za && ib);
        if (na || nb || inv0) begin
            res = qnan; flg = {inv0 || sna || snb, 3'b000};
        end else if (ia || ib) begin
            res = infv; flg = 4'b0000;
        end else if (za || zb) begin
            res = sgn; flg = 4'b0000;
        end else begin
            p = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
            e = ea + eb - bias;
            if (p >= (64'd1 << (2 * mw + 1))) begin sh = mw + 1; e++; end
            else sh = mw;
            q = p >> sh;
            r = p & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (e <= 0) begin
                res = sgn; flg = 4'b0011;
            end else begin
                if (r > half || (r == half && q[0])) q++;
                if (q >= (64'd2 << mw)) begin q = q >> 1; e++; end
                if (e >= emaxf) begin
                    res = infv; flg = 4'b0101;
                end else begin
                    res = sgn | (longint'(e) << mw) | (q & mmask);
                    flg = {3'b000, r != 0};
                end
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 6) r[30:23] = 8'($urandom_range(100, 154));
        else if (sel == 6) r[30:23] = 8'($urandom_range(0, 3));
        else if (sel == 7) r[30:23] = 8'($urandom_range(250, 255));
        return r;
    endfunction

    function automatic logic [15:0] rand_h();
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 3) != 0) r[14:10] = 5'($urandom_range(9, 21));
        return r;
    endfunction

    task automatic monitor();
        logic [35:0] e;
        logic        prev_stall;
        logic [35:0] prev_out;
        prev_stall = 1'b0;
        prev_out = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", {flags, result}, prev_out);
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) check("spurious_out", out_valid, 0);
                    else begin
                        e = expq.pop_front();
                        check("result", result, e[31:0]);
                        check("flags", flags, e[35:32]);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out = {flags, result};
                if (prev_stall) stall_cycles++;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [35:0] e);
        int n;
        num1 = a; num2 = b; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check("accept", in_ready, 1);
        expq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue_m(input logic [31:0] a, input logic [31:0] b);
        longint unsigned r;
        logic [3:0] f;
        ref_mul(64'(a), 64'(b), 8, 23, r, f);
        issue(a, b, {f, r[31:0]});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            @(negedge clk); n++;
        end
        check("drain", expq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic h_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [3:0] ef);
        int n;
        h_num1 = a; h_num2 = b; h_in_valid = 1'b1;
        #1;
        check("h_in_ready", h_in_ready, 1);
        @(negedge clk);
        h_in_valid = 1'b0;
        n = 0;
        #2;
        while (!h_out_valid && n < 10) begin
            @(negedge clk); #2; n++;
        end
        check("h_latency", n, 3);
        check("h_result", h_result, er);
        check("h_flags", h_flags, ef);
        @(negedge clk);
    endtask

    initial begin
        int stall_base;
        longint unsigned hr;
        logic [3:0] hf;
        logic [15:0] ha, hb;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        num1 = 32'h3F800000; num2 = 32'h40000000;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_num1 = '0; h_num2 = '0;
        fork monitor(); join_none

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_no_accept", out_valid, 0);

        issue(32'h40200000, 32'h3FA00000, {4'b0000, 32'h40480000});
        for (int k = 0; k < 4; k++) begin
            #2;
            check("latency", out_valid, (k == 3));
            @(negedge clk);
        end

        issue(32'h3F800001, 32'h3F800001, {4'b0001, 32'h3F800002});
        issue(32'h3FFFFFFF, 32'h3FFFFFFF, {4'b0001, 32'h407FFFFE});
        issue(32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000});
        issue(32'h00000000, 32'hFF800000, {4'b1000, 32'h7FC00000});
        issue(32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000});
        issue(32'h7FC00001, 32'h3F800000, {4'b0000, 32'h7FC00000});
        issue(32'h7F800001, 32'h3F800000, {4'b1000, 32'h7FC00000});
        issue(32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000});
        issue(32'h00800000, 32'h3F000000, {4'b0011, 32'h00000000});
        issue(32'h00000001, 32'h3F800000, {4'b0000, 32'h00000000});
        issue(32'h80000000, 32'h3F800000, {4'b0000, 32'h80000000});
        issue(32'hC0000000, 32'h3F400000, {4'b0000, 32'hBFC00000});
        drain();

        stall_base = stall_cycles;
        fork
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 5; i++) issue_m(rand_op(), rand_op());
        drain();
        check("stall_seen", (stall_cycles - stall_base) >= 3, 1);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            num1 = rand_op(); num2 = rand_op(); in_valid = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("flush_valid", out_valid, 0);
        check("flush_result", result, 0);
        check("flush_flags", flags, 0);
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #2;
            check("flush_quiet", out_valid, 0);
        end
        @(negedge clk);

        h_op(16'h4100, 16'h3E00, 16'h4380, 4'b0000);
        h_op(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
        h_op(16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
        for (int i = 0; i < 20; i++) begin
            ha = rand_h(); hb = rand_h();
            ref_mul(64'(ha), 64'(hb), 5, 10, hr, hf);
            h_op(ha, hb, hr[15:0], hf);
        end

        fork
            begin
                repeat (800) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            issue_m(rand_op(), rand_op());
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
